// File: rtl/multi_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_timer_ctrl_pkg
//  Purpose  : Shared state encoding, boolean constants and BCD digit limits
//             for the stopwatch/timer controller and its BCD time counter.
//  Revision : 1.0 - initial release
// ============================================================================
package multi_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        DN_IDLE   = 3'd0,
        DN_RUN    = 3'd1,
        DN_PAUSE  = 3'd2,
        DN_SET    = 3'd3,
        UP_STOP   = 3'd4,
        UP_RUN    = 3'd5,
        UP_LAP    = 3'd6,
        UP_REVIEW = 3'd7
    } state_t;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    // Digit 1 (tens of the lowest time field) counts 0..5, every other digit 0..9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 1) ? 4'd5 : 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_time_counter
//  Purpose  : Multi-digit BCD time counter with clear, load, saturating
//             increment and floor-at-zero decrement.
//  Ports    : clk, rst_n          clock / async active-low reset
//             clr, load           clear to zero / load din (clr wins)
//             up_en, down_en      single-step increment / decrement
//             din, q              load value / current count
//             all_zero, all_max   count is zero / every digit at its maximum
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter
    import multi_timer_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clr,
    input  logic                  up_en,
    input  logic                  down_en,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  all_zero,
    output logic                  all_max
);

    logic [4*DIGITS-1:0] r_q;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic                w_carry;
    logic                w_borrow;
    logic                w_max;

    // Ripple carry/borrow from the least significant digit upwards.
    always_comb begin
        w_inc    = r_q;
        w_dec    = r_q;
        w_carry  = c_TRUE;
        w_borrow = c_TRUE;
        w_max    = c_TRUE;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_q[4*i +: 4] != digit_max(i)) begin
                w_max = c_FALSE;
            end
            if (w_carry) begin
                // ">=" also folds an out-of-range loaded digit back to zero
                if (r_q[4*i +: 4] >= digit_max(i)) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_q[4*i +: 4] + 4'd1;
                    w_carry         = c_FALSE;
                end
            end
            if (w_borrow) begin
                if (r_q[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = digit_max(i);
                end else begin
                    w_dec[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
                    w_borrow        = c_FALSE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (up_en && !w_max) begin
            r_q <= w_inc;
        end else if (down_en && (r_q != '0)) begin
            r_q <= w_dec;
        end
    end

    assign q        = r_q;
    assign all_zero = (r_q == '0);
    assign all_max  = w_max;

endmodule
`default_nettype wire

// File: rtl/multi_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multi_timer_ctrl
//  Purpose  : Stopwatch / count-down timer controller with BCD time counter,
//             circular lap memory and registered display mux.
//  Ports    : clk, rst_n                 clock / async active-low reset
//             tick_en                    time-base enable (1 cycle)
//             pb_mode, pb_l, pb_l_long,  one-cycle button pulses
//             pb_r
//             switch                     setting-mode level (down mode)
//             set_value                  BCD count-down preset
//             disp_bcd                   displayed value (registered)
//             state                      current FSM state
//             lap_idx                    recalled slot / next write slot
//             lap_cnt                    laps stored (saturating)
//             done                       count-down reached zero (pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module multi_timer_ctrl
    import multi_timer_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int LAP_DEPTH = 4,
    parameter int LAP_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_en,
    input  logic                  pb_mode,
    input  logic                  pb_l,
    input  logic                  pb_l_long,
    input  logic                  pb_r,
    input  logic                  switch,
    input  logic [4*DIGITS-1:0]   set_value,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [2:0]            state,
    output logic [LAP_W-1:0]      lap_idx,
    output logic [LAP_W:0]        lap_cnt,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    state_t             r_state;
    logic [W-1:0]       r_lap [LAP_DEPTH];
    logic [LAP_W-1:0]   r_wr_ptr;
    logic [LAP_W-1:0]   r_rev_idx;
    logic [LAP_W:0]     r_lap_cnt;
    logic               r_done;
    logic [W-1:0]       r_disp;

    logic [W-1:0]       w_count;
    logic               w_all_zero;
    logic               w_all_max;
    logic               w_clr;
    logic               w_load;
    logic               w_up_en;
    logic               w_down_en;
    logic [LAP_W-1:0]   w_newest;
    logic [LAP_W-1:0]   w_oldest;
    logic [W-1:0]       w_disp_nxt;

    // Only the highest-priority button of a cycle is acted on.
    logic w_mode, w_long, w_l, w_r, w_sw;
    assign w_mode = pb_mode;
    assign w_long = pb_l_long & ~pb_mode;
    assign w_l    = pb_l & ~pb_l_long & ~pb_mode;
    assign w_r    = pb_r & ~pb_l & ~pb_l_long & ~pb_mode;
    assign w_sw   = switch & ~pb_r & ~pb_l & ~pb_l_long & ~pb_mode;

    // Slot arithmetic wraps naturally in LAP_W bits; with a full buffer the
    // oldest slot is the next write slot, otherwise it is slot 0.
    assign w_newest = r_wr_ptr - LAP_W'(1);
    assign w_oldest = r_wr_ptr - r_lap_cnt[LAP_W-1:0];

    // Ticks follow the current state, so a stop/pause in the same cycle
    // still lets that tick through.
    assign w_up_en   = tick_en & ((r_state == UP_RUN) || (r_state == UP_LAP));
    assign w_down_en = tick_en & (r_state == DN_RUN);

    always_comb begin
        w_clr  = c_FALSE;
        w_load = c_FALSE;
        case (r_state)
            DN_IDLE: begin
                if (w_mode)   w_clr  = c_TRUE;
                else if (w_l) w_load = c_TRUE;
            end
            DN_SET:  w_load = c_TRUE;
            UP_STOP: begin
                if (w_mode || w_long) w_clr = c_TRUE;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_state)
            UP_LAP:    w_disp_nxt = r_lap[w_newest];
            UP_REVIEW: w_disp_nxt = r_lap[r_rev_idx];
            default:   w_disp_nxt = w_count;
        endcase
    end

    bcd_time_counter #(
        .DIGITS   (DIGITS)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .clr      (w_clr),
        .up_en    (w_up_en),
        .down_en  (w_down_en),
        .din      (set_value),
        .q        (w_count),
        .all_zero (w_all_zero),
        .all_max  (w_all_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DN_IDLE;
            r_wr_ptr  <= '0;
            r_rev_idx <= '0;
            r_lap_cnt <= '0;
            r_done    <= c_FALSE;
            r_disp    <= '0;
            for (int k = 0; k < LAP_DEPTH; k++) r_lap[k] <= '0;
        end else begin
            r_done <= c_FALSE;
            r_disp <= w_disp_nxt;
            case (r_state)
                DN_IDLE: begin
                    if (w_mode)     r_state <= UP_STOP;
                    else if (w_l)   r_state <= DN_RUN;
                    else if (w_sw)  r_state <= DN_SET;
                end
                DN_SET: begin
                    if (!switch)    r_state <= DN_IDLE;
                end
                DN_RUN: begin
                    if (w_all_zero) begin
                        r_state <= DN_IDLE;
                        r_done  <= c_TRUE;
                    end else if (w_l) begin
                        r_state <= DN_IDLE;
                    end else if (w_r) begin
                        r_state <= DN_PAUSE;
                    end
                end
                DN_PAUSE: begin
                    if (w_l)        r_state <= DN_IDLE;
                    else if (w_r)   r_state <= DN_RUN;
                end
                UP_STOP: begin
                    if (w_mode) begin
                        r_state <= DN_IDLE;
                    end else if (w_long) begin
                        r_wr_ptr  <= '0;
                        r_lap_cnt <= '0;
                        for (int k = 0; k < LAP_DEPTH; k++) r_lap[k] <= '0;
                    end else if (w_l) begin
                        r_state <= UP_RUN;
                    end else if (w_r && (r_lap_cnt != '0)) begin
                        r_state   <= UP_REVIEW;
                        r_rev_idx <= w_newest;
                    end
                end
                UP_RUN: begin
                    if (w_l) begin
                        r_state <= UP_STOP;
                    end else if (w_r) begin
                        r_lap[r_wr_ptr] <= w_count;
                        r_wr_ptr        <= r_wr_ptr + LAP_W'(1);
                        if (r_lap_cnt != (LAP_W+1)'(LAP_DEPTH))
                            r_lap_cnt <= r_lap_cnt + (LAP_W+1)'(1);
                        r_state <= UP_LAP;
                    end
                end
                UP_LAP: begin
                    if (w_l)        r_state <= UP_STOP;
                    else if (w_r)   r_state <= UP_RUN;
                end
                UP_REVIEW: begin
                    if (w_l) begin
                        r_state <= UP_STOP;
                    end else if (w_r) begin
                        r_rev_idx <= (r_rev_idx == w_oldest) ? w_newest
                                                             : r_rev_idx - LAP_W'(1);
                    end
                end
                default: r_state <= DN_IDLE;
            endcase
        end
    end

    assign disp_bcd = r_disp;
    assign state    = r_state;
    assign lap_idx  = (r_state == UP_REVIEW) ? r_rev_idx : r_wr_ptr;
    assign lap_cnt  = r_lap_cnt;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_timer_ctrl
//  Purpose  : Directed self-checking bench for multi_timer_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tick_en;
    logic        pb_mode;
    logic        pb_l;
    logic        pb_l_long;
    logic        pb_r;
    logic        switch;
    logic [15:0] set_value;
    logic [15:0] disp_bcd;
    logic [2:0]  state;
    logic [1:0]  lap_idx;
    logic [2:0]  lap_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;

    multi_timer_ctrl #(
        .DIGITS    (4),
        .LAP_DEPTH (4),
        .LAP_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .pb_mode   (pb_mode),
        .pb_l      (pb_l),
        .pb_l_long (pb_l_long),
        .pb_r      (pb_r),
        .switch    (switch),
        .set_value (set_value),
        .disp_bcd  (disp_bcd),
        .state     (state),
        .lap_idx   (lap_idx),
        .lap_cnt   (lap_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One clock edge; pulses and tick are dropped afterwards, sample point is edge+1.
    task automatic clk1();
        @(posedge clk);
        #1;
        tick_en   = 1'b0;
        pb_mode   = 1'b0;
        pb_l      = 1'b0;
        pb_l_long = 1'b0;
        pb_r      = 1'b0;
    endtask

    task automatic tick1();
        tick_en = 1'b1;
        clk1();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  exp_idx  [5];
    logic [15:0] exp_disp [5];

    initial begin
        rst_n = 1'b0; tick_en = 1'b0; pb_mode = 1'b0; pb_l = 1'b0;
        pb_l_long = 1'b0; pb_r = 1'b0; switch = 1'b0; set_value = 16'h0000;
        #12;
        check("rst_state",   32'(state),    32'd0);
        check("rst_disp",    32'(disp_bcd), 32'h0);
        check("rst_lap_cnt", 32'(lap_cnt),  32'd0);
        check("rst_lap_idx", 32'(lap_idx),  32'd0);
        check("rst_done",    32'(done),     32'd0);
        rst_n = 1'b1;
        clk1();

        // Count-down 3 -> 0, done pulse once
        set_value = 16'h0003; pb_l = 1'b1; clk1();
        check("dn_start_state", 32'(state), 32'd1);
        tick1(); check("dn_disp3", 32'(disp_bcd), 32'h0003);
        tick1(); check("dn_disp2", 32'(disp_bcd), 32'h0002);
        tick1(); check("dn_disp1", 32'(disp_bcd), 32'h0001);
        check("dn_not_done_yet", 32'(done), 32'd0);
        clk1();
        check("dn_done",       32'(done),     32'd1);
        check("dn_idle_state", 32'(state),    32'd0);
        check("dn_disp0",      32'(disp_bcd), 32'h0000);
        clk1();
        check("dn_done_pulse", 32'(done), 32'd0);

        // Pause holds count, resume borrows 0100 -> 0059
        set_value = 16'h0100; pb_l = 1'b1; clk1();
        pb_r = 1'b1; clk1();
        check("pause_state", 32'(state), 32'd2);
        for (int i = 0; i < 5; i++) tick1();
        check("pause_hold", 32'(disp_bcd), 32'h0100);
        pb_r = 1'b1; clk1();
        check("resume_state", 32'(state), 32'd1);
        tick1(); clk1();
        check("borrow_0059", 32'(disp_bcd), 32'h0059);
        pb_l = 1'b1; clk1();
        check("dn_stop_state", 32'(state), 32'd0);

        // Setting mode tracks set_value
        switch = 1'b1; clk1();
        check("set_state", 32'(state), 32'd3);
        set_value = 16'h1234; clk1();
        switch = 1'b0; clk1(); clk1();
        check("set_exit_state", 32'(state),    32'd0);
        check("set_value_disp", 32'(disp_bcd), 32'h1234);

        // pb_mode beats pb_l in the same cycle; mode change zeroes count
        pb_mode = 1'b1; pb_l = 1'b1; clk1();
        check("mode_prio_state", 32'(state), 32'd4);
        clk1();
        check("mode_zero_disp", 32'(disp_bcd), 32'h0000);

        // Count-up carry 0059 -> 0100
        pb_l = 1'b1; clk1();
        check("up_run_state", 32'(state), 32'd5);
        for (int i = 0; i < 59; i++) tick1();
        clk1();
        check("up_0059", 32'(disp_bcd), 32'h0059);
        tick1(); clk1();
        check("up_carry_0100", 32'(disp_bcd), 32'h0100);

        // Lap freeze at 0012 while count runs to 0015
        pb_l = 1'b1; clk1();
        pb_l_long = 1'b1; clk1();
        pb_l = 1'b1; clk1();
        for (int i = 0; i < 12; i++) tick1();
        pb_r = 1'b1; clk1();
        check("lap_state",    32'(state),   32'd6);
        check("lap_cnt1",     32'(lap_cnt), 32'd1);
        check("lap_idx_wr1",  32'(lap_idx), 32'd1);
        for (int i = 0; i < 3; i++) tick1();
        check("lap_frozen", 32'(disp_bcd), 32'h0012);
        pb_r = 1'b1; clk1(); clk1();
        check("lap_release_disp", 32'(disp_bcd), 32'h0015);
        check("lap_release_state", 32'(state),  32'd5);

        // Four more laps: 0016..0019, slot 0 overwritten by 0019
        for (int i = 0; i < 4; i++) begin
            tick1();
            pb_r = 1'b1; clk1();
            pb_r = 1'b1; clk1();
        end
        check("lap_cnt_sat", 32'(lap_cnt), 32'd4);
        check("lap_wr_wrap", 32'(lap_idx), 32'd1);
        pb_l = 1'b1; clk1();
        check("up_stop_state", 32'(state), 32'd4);

        // Recall newest..oldest then wrap to newest
        exp_idx[0] = 2'd0; exp_disp[0] = 16'h0019;
        exp_idx[1] = 2'd3; exp_disp[1] = 16'h0018;
        exp_idx[2] = 2'd2; exp_disp[2] = 16'h0017;
        exp_idx[3] = 2'd1; exp_disp[3] = 16'h0016;
        exp_idx[4] = 2'd0; exp_disp[4] = 16'h0019;
        for (int i = 0; i < 5; i++) begin
            pb_r = 1'b1; clk1();
            check("review_idx", 32'(lap_idx), 32'(exp_idx[i]));
            clk1();
            check("review_disp", 32'(disp_bcd), 32'(exp_disp[i]));
        end
        check("review_state", 32'(state), 32'd7);
        pb_l = 1'b1; clk1();

        // Long press clears laps and count
        pb_l_long = 1'b1; clk1();
        check("long_lap_cnt", 32'(lap_cnt), 32'd0);
        check("long_lap_idx", 32'(lap_idx), 32'd0);
        clk1();
        check("long_disp", 32'(disp_bcd), 32'h0000);
        pb_r = 1'b1; clk1();
        check("no_review_empty", 32'(state), 32'd4);

        // Saturation at all-max 99:59 (5999 ticks from zero)
        pb_l = 1'b1; clk1();
        for (int i = 0; i < 5999; i++) tick1();
        clk1();
        check("up_all_max", 32'(disp_bcd), 32'h9959);
        tick1(); clk1();
        check("up_sat_hold", 32'(disp_bcd), 32'h9959);

        // Asynchronous reset mid-run with a lap stored
        pb_r = 1'b1; clk1();
        pb_r = 1'b1; clk1();
        check("pre_rst_lap_cnt", 32'(lap_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state",   32'(state),    32'd0);
        check("arst_disp",    32'(disp_bcd), 32'h0000);
        check("arst_lap_cnt", 32'(lap_cnt),  32'd0);
        check("arst_lap_idx", 32'(lap_idx),  32'd0);
        #1 rst_n = 1'b1;
        clk1();
        check("post_rst_state", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
